// File: rtl/bcd_counter_scan.sv
// rtl/bcd_counter_scan.sv - two-digit BCD up/down counter with prescaled tick and scanned digit output
module bcd_counter_scan #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       carry,
  output logic [3:0] bcd_digit,
  output logic [1:0] digit_sel
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [7:0]        count_q, count_d;
  logic              carry_q, carry_d;
  logic [3:0]        bcd_digit_q, bcd_digit_d;
  logic [1:0]        digit_sel_q, digit_sel_d;
  logic              tick;
  logic              scan_wrap;
  logic              load_ok;
  logic [3:0]        ones_d, tens_d;

  // Clear realigns the tick phase so the next step is a full period away.
  always_comb begin
    tick       = en && (tick_cnt_q == TICK_MAX);
    tick_cnt_d = tick_cnt_q;
    if (clr) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
    end else if (en) begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  always_comb begin
    load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
    ones_d  = count_q[3:0];
    tens_d  = count_q[7:4];
    carry_d = 1'b0;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (load) begin
      if (load_ok) begin
        ones_d = load_val[3:0];
        tens_d = load_val[7:4];
      end
    end else if (tick) begin
      if (up) begin
        if (count_q[3:0] == 4'd9) begin
          ones_d = 4'd0;
          if (count_q[7:4] == 4'd9) begin
            tens_d  = 4'd0;
            carry_d = 1'b1;
          end else begin
            tens_d = count_q[7:4] + 4'd1;
          end
        end else begin
          ones_d = count_q[3:0] + 4'd1;
        end
      end else begin
        if (count_q[3:0] == 4'd0) begin
          ones_d = 4'd9;
          if (count_q[7:4] == 4'd0) begin
            tens_d  = 4'd9;
            carry_d = 1'b1;
          end else begin
            tens_d = count_q[7:4] - 4'd1;
          end
        end else begin
          ones_d = count_q[3:0] - 4'd1;
        end
      end
    end
    count_d = {tens_d, ones_d};
  end

  // The digit follows the select value taken on this same edge, from the pre-edge count.
  always_comb begin
    scan_wrap   = (scan_cnt_q == SCAN_MAX);
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    digit_sel_d = scan_wrap ? {digit_sel_q[0], digit_sel_q[1]} : digit_sel_q;
    bcd_digit_d = digit_sel_d[0] ? count_q[3:0] : count_q[7:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      count_q     <= 8'h00;
      carry_q     <= 1'b0;
      bcd_digit_q <= 4'h0;
      digit_sel_q <= 2'b01;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      bcd_digit_q <= bcd_digit_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign count     = count_q;
  assign carry     = carry_q;
  assign bcd_digit = bcd_digit_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// tb/tb_bcd_counter_scan.sv - self-checking bench for bcd_counter_scan
module tb_bcd_counter_scan;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count;
  logic       carry;
  logic [3:0] bcd_digit;
  logic [1:0] digit_sel;

  int errors = 0;
  int checks = 0;

  // Reference model: integer value 0..99 and integer phase counters.
  int m_val, m_tph, m_sph, m_bcd;
  bit m_carry, m_sel_ones;

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] lv;
    logic [7:0] exp_cnt;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[35];

  bcd_counter_scan #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count), .carry(carry),
    .bcd_digit(bcd_digit), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_tph = 0; m_sph = 0; m_bcd = 0;
    m_carry = 0; m_sel_ones = 1;
  endtask

  task automatic model_edge();
    int  old;
    bit  tk;
    old = m_val;
    if (m_sph == SCAN_DIV - 1) begin
      m_sph = 0;
      m_sel_ones = !m_sel_ones;
    end else begin
      m_sph++;
    end
    m_bcd = m_sel_ones ? old % 10 : old / 10;
    m_carry = 0;
    if (clr) begin
      m_val = 0;
      m_tph = 0;
    end else begin
      tk = en && (m_tph == TICK_DIV - 1);
      if (en) m_tph = (m_tph + 1) % TICK_DIV;
      if (load) begin
        if (load_val[7:4] < 10 && load_val[3:0] < 10)
          m_val = 10 * int'(load_val[7:4]) + int'(load_val[3:0]);
      end else if (tk) begin
        if (up) begin
          m_val++;
          if (m_val == 100) begin m_val = 0; m_carry = 1; end
        end else if (m_val == 0) begin
          m_val = 99; m_carry = 1;
        end else begin
          m_val--;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".count"}, count, to_bcd(m_val));
    chk({tag, ".carry"}, {7'b0, carry}, {7'b0, m_carry});
    chk({tag, ".digit_sel"}, {6'b0, digit_sel}, m_sel_ones ? 8'h01 : 8'h02);
    chk({tag, ".bcd_digit"}, {4'b0, bcd_digit}, 8'(m_bcd));
  endtask

  initial begin
    int toggles;
    logic [1:0] prev_sel;

    //          clr load en up lv     cnt  carry
    vecs[0]  = '{0, 1, 0, 1, 8'h98, 8'h98, 0};
    vecs[1]  = '{0, 0, 1, 1, 8'h00, 8'h98, 0};
    vecs[2]  = '{0, 0, 1, 1, 8'h00, 8'h98, 0};
    vecs[3]  = '{0, 0, 1, 1, 8'h00, 8'h98, 0};
    vecs[4]  = '{0, 0, 1, 1, 8'h00, 8'h99, 0};
    vecs[5]  = '{0, 0, 1, 1, 8'h00, 8'h99, 0};
    vecs[6]  = '{0, 0, 1, 1, 8'h00, 8'h99, 0};
    vecs[7]  = '{0, 0, 1, 1, 8'h00, 8'h99, 0};
    vecs[8]  = '{0, 0, 1, 1, 8'h00, 8'h00, 1};
    vecs[9]  = '{0, 0, 0, 1, 8'h00, 8'h00, 0};
    vecs[10] = '{0, 0, 1, 0, 8'h00, 8'h00, 0};
    vecs[11] = '{0, 0, 1, 0, 8'h00, 8'h00, 0};
    vecs[12] = '{0, 0, 1, 0, 8'h00, 8'h00, 0};
    vecs[13] = '{0, 0, 1, 0, 8'h00, 8'h99, 1};
    vecs[14] = '{0, 0, 0, 0, 8'h00, 8'h99, 0};
    vecs[15] = '{0, 0, 1, 0, 8'h00, 8'h99, 0};
    vecs[16] = '{0, 0, 1, 0, 8'h00, 8'h99, 0};
    vecs[17] = '{0, 0, 1, 0, 8'h00, 8'h99, 0};
    vecs[18] = '{0, 0, 1, 0, 8'h00, 8'h98, 0};
    vecs[19] = '{0, 1, 0, 1, 8'h5A, 8'h98, 0};
    vecs[20] = '{0, 1, 0, 1, 8'hA3, 8'h98, 0};
    vecs[21] = '{1, 1, 1, 1, 8'h42, 8'h00, 0};
    vecs[22] = '{0, 1, 0, 1, 8'h37, 8'h37, 0};
    vecs[23] = '{0, 0, 1, 1, 8'h00, 8'h37, 0};
    vecs[24] = '{0, 0, 1, 1, 8'h00, 8'h37, 0};
    vecs[25] = '{0, 0, 1, 1, 8'h00, 8'h37, 0};
    vecs[26] = '{0, 1, 1, 1, 8'h25, 8'h25, 0};
    vecs[27] = '{0, 0, 1, 1, 8'h00, 8'h25, 0};
    vecs[28] = '{0, 0, 1, 1, 8'h00, 8'h25, 0};
    vecs[29] = '{0, 0, 1, 1, 8'h00, 8'h25, 0};
    vecs[30] = '{1, 0, 1, 1, 8'h00, 8'h00, 0};
    vecs[31] = '{0, 0, 1, 1, 8'h00, 8'h00, 0};
    vecs[32] = '{0, 0, 1, 1, 8'h00, 8'h00, 0};
    vecs[33] = '{0, 0, 1, 1, 8'h00, 8'h00, 0};
    vecs[34] = '{0, 0, 1, 1, 8'h00, 8'h01, 0};

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_model("reset");
    rst_n = 1'b1;

    // Free count up for 40 cycles: one step every TICK_DIV edges
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("count_up.count", count, to_bcd(k / TICK_DIV));
      chk("count_up.carry", {7'b0, carry}, 8'h00);
    end
    chk_model("count_up_end");

    // Asynchronous reset between edges, mid-count
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst.count", count, 8'h00);
    chk("async_rst.carry", {7'b0, carry}, 8'h00);
    chk("async_rst.digit_sel", {6'b0, digit_sel}, 8'h01);
    chk("async_rst.bcd_digit", {4'b0, bcd_digit}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k < TICK_DIV; k++) begin
      step();
      chk("post_rst.hold", count, 8'h00);
    end
    step();
    chk("post_rst.first_tick", count, 8'h01);

    // Table of clr/load/tick vectors, starting from tick phase 0
    for (int i = 0; i < 35; i++) begin
      clr = vecs[i].clr; load = vecs[i].load; en = vecs[i].en;
      up = vecs[i].up; load_val = vecs[i].lv;
      step();
      chk($sformatf("vec%0d.count", i), count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d.carry", i), {7'b0, carry}, {7'b0, vecs[i].exp_carry});
    end
    clr = 1'b0; load = 1'b0;
    chk_model("after_table");

    // Digit scan with a held count of 37
    en = 1'b0; load = 1'b1; load_val = 8'h37;
    step();
    load = 1'b0;
    step();
    toggles = 0;
    prev_sel = digit_sel;
    for (int k = 0; k < 8; k++) begin
      step();
      if (digit_sel != prev_sel) toggles++;
      prev_sel = digit_sel;
      chk("scan.digit_sel", {6'b0, digit_sel}, m_sel_ones ? 8'h01 : 8'h02);
      chk("scan.bcd_digit", {4'b0, bcd_digit}, (digit_sel == 2'b10) ? 8'h03 : 8'h07);
    end
    chk("scan.toggles", 8'(toggles), 8'd4);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 3) != 0);
      up = ((k / 80) % 2 == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 31) == 0);
      load = ($urandom_range(0, 11) == 0);
      load_val = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
      step();
      chk_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
